// File: rtl/stack_mem_arbiter_if.sv
// DMA/debug port and single-port memory bus seen by the stack/memory arbiter.
// master = arbiter side, slave = DMA agent plus memory side.
interface stack_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  dma_req, dma_we, dma_addr,
    input  dma_wdata, mem_rdata,
    output dma_gnt, dma_rvalid,
    output mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport slave (
    output dma_req, dma_we, dma_addr,
    output dma_wdata, mem_rdata,
    input  dma_gnt, dma_rvalid,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/stack_mem_arbiter.sv
// Shares the single-port data memory between core load/store/push/pop and a
// DMA port; owns the downward-growing stack pointer and the core Stall.
module stack_mem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int STACK_BASE   = 1023,
  parameter int STACK_DEPTH  = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        StackOp,
  input  logic [DATA_W-1:0] PushData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemWData,
  output logic              Stall,
  output logic [DATA_W-1:0] RData,
  output logic              RDataValid,
  output logic [ADDR_W-1:0] Sp,
  output logic              StackFull,
  output logic              StackEmpty,
  output logic              StackErr,
  stack_mem_arbiter_if.master bus
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE, CORE_RD, DMA_RD
  } state_t;

  state_t            state, nextState;
  logic [CW-1:0]     cnt, cntNext;
  logic [SW-1:0]     starve;
  logic              zeroFlag, zeroNext;
  logic              errSet;
  logic [DATA_W-1:0] rDataQ, rdSel;

  logic push, pop, coreReq, starveHit;
  logic selRd, selWr;

  assign push    = StackOp == 2'b10;
  assign pop     = StackOp == 2'b11;
  assign coreReq = push | pop | MemRead | MemWrite;
  assign selRd   = MemRead & ~push & ~pop;
  assign selWr   = MemWrite & ~push & ~pop & ~MemRead;

  assign starveHit  = starve >= SW'(STARVE_LIMIT);
  assign StackFull  = cnt == CW'(STACK_DEPTH);
  assign StackEmpty = cnt == '0;
  assign Sp = ADDR_W'(STACK_BASE) - ADDR_W'(cnt);

  // Zero flag marks a pop from an empty stack: return 0 instead of memory.
  assign rdSel = zeroFlag ? '0 : bus.mem_rdata;
  assign RData = rst ? '0 : (RDataValid ? rdSel : rDataQ);

  always_comb begin
    nextState      = state;
    cntNext        = cnt;
    zeroNext       = zeroFlag;
    errSet         = 1'b0;
    Stall          = 1'b0;
    RDataValid     = 1'b0;
    bus.dma_gnt    = 1'b0;
    bus.dma_rvalid = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (bus.dma_req && (!coreReq || starveHit)) begin
            bus.dma_gnt   = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dma_we;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            Stall         = coreReq;
            if (!bus.dma_we) nextState = DMA_RD;
          end else if (coreReq) begin
            unique case (1'b1)
              push: begin
                if (!StackFull) begin
                  bus.mem_en    = 1'b1;
                  bus.mem_we    = 1'b1;
                  bus.mem_addr  = Sp;
                  bus.mem_wdata = PushData;
                  cntNext       = cnt + CW'(1);
                end else begin
                  errSet = 1'b1;
                end
              end
              pop: begin
                Stall     = 1'b1;
                nextState = CORE_RD;
                zeroNext  = StackEmpty;
                if (!StackEmpty) begin
                  bus.mem_en   = 1'b1;
                  bus.mem_addr = Sp + ADDR_W'(1);
                  cntNext      = cnt - CW'(1);
                end else begin
                  errSet = 1'b1;
                end
              end
              selRd: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = MemAddr;
                Stall        = 1'b1;
                zeroNext     = 1'b0;
                nextState    = CORE_RD;
              end
              selWr: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = MemAddr;
                bus.mem_wdata = MemWData;
              end
              default: ;
            endcase
          end
        end
        CORE_RD: begin
          RDataValid = 1'b1;
          nextState  = IDLE;
        end
        DMA_RD: begin
          bus.dma_rvalid = 1'b1;
          Stall          = coreReq;
          nextState      = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      starve   <= '0;
      zeroFlag <= 1'b0;
      rDataQ   <= '0;
      StackErr <= 1'b0;
    end else begin
      state    <= nextState;
      cnt      <= cntNext;
      zeroFlag <= zeroNext;
      if (errSet) StackErr <= 1'b1;
      if (RDataValid) rDataQ <= rdSel;
      if (bus.dma_req && !bus.dma_gnt)
        starve <= starveHit ? starve : starve + SW'(1);
      else
        starve <= '0;
    end
  end
endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Vector-table bench for stack_mem_arbiter with a behavioural
// single-port memory (registered read) on the memory side.
module tb_stack_mem_arbiter;
  localparam logic [1:0] N  = 2'b00;
  localparam logic [1:0] PU = 2'b10;
  localparam logic [1:0] PO = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  StackOp;
  logic [31:0] PushData;
  logic        MemRead, MemWrite;
  logic [9:0]  MemAddr;
  logic [31:0] MemWData;
  logic        Stall, RDataValid;
  logic [31:0] RData;
  logic [9:0]  Sp;
  logic        StackFull, StackEmpty, StackErr;
  logic [31:0] mem [1024];

  stack_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  stack_mem_arbiter #(
    .DATA_W(32), .ADDR_W(10), .STACK_BASE(1023),
    .STACK_DEPTH(4), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .StackOp(StackOp), .PushData(PushData),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemWData(MemWData),
    .Stall(Stall), .RData(RData),
    .RDataValid(RDataValid), .Sp(Sp),
    .StackFull(StackFull), .StackEmpty(StackEmpty),
    .StackErr(StackErr), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic rst; logic [1:0] op; logic [31:0] pd;
    logic rd; logic wr; logic [9:0] addr; logic [31:0] wd;
    logic dreq; logic dwe; logic [9:0] da; logic [31:0] dwd;
  } in_t;

  typedef struct {
    logic stall; logic rv; logic [31:0] rdata; logic [9:0] sp;
    logic full; logic empty; logic err;
    logic gnt; logic drv; logic en; logic we;
    logic [9:0] ma; logic [31:0] mwd;
  } exp_t;

  typedef struct { in_t i; exp_t e; } vec_t;

  vec_t vt[$];
  int applied = 0;
  int miscompares = 0;

  function automatic in_t I(
    logic r, logic [1:0] op, logic [31:0] pd,
    logic rd, logic wr, logic [9:0] a, logic [31:0] wd,
    logic dq, logic dw, logic [9:0] da, logic [31:0] dd);
    in_t v;
    v = '{r, op, pd, rd, wr, a, wd, dq, dw, da, dd};
    return v;
  endfunction

  function automatic exp_t E(
    logic st, logic rv, logic [31:0] rdt, logic [9:0] sp,
    logic fu, logic em, logic er, logic g, logic dv,
    logic en, logic we, logic [9:0] ma, logic [31:0] mw);
    exp_t v;
    v = '{st, rv, rdt, sp, fu, em, er, g, dv, en, we, ma, mw};
    return v;
  endfunction

  task automatic add(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vt.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rst = i.rst; StackOp = i.op; PushData = i.pd;
    MemRead = i.rd; MemWrite = i.wr;
    MemAddr = i.addr; MemWData = i.wd;
    bus.dma_req = i.dreq; bus.dma_we = i.dwe;
    bus.dma_addr = i.da; bus.dma_wdata = i.dwd;
  endtask

  task automatic chk(input int n, input string nm,
                     input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL v%0d %s got=%h exp=%h", n, nm, got, want);
    end
  endtask

  task automatic check(input int n, input exp_t e);
    chk(n, "Stall", 32'(Stall), 32'(e.stall));
    chk(n, "RDataValid", 32'(RDataValid), 32'(e.rv));
    chk(n, "RData", RData, e.rdata);
    chk(n, "Sp", 32'(Sp), 32'(e.sp));
    chk(n, "StackFull", 32'(StackFull), 32'(e.full));
    chk(n, "StackEmpty", 32'(StackEmpty), 32'(e.empty));
    chk(n, "StackErr", 32'(StackErr), 32'(e.err));
    chk(n, "dma_gnt", 32'(bus.dma_gnt), 32'(e.gnt));
    chk(n, "dma_rvalid", 32'(bus.dma_rvalid), 32'(e.drv));
    chk(n, "mem_en", 32'(bus.mem_en), 32'(e.en));
    if (e.en) begin
      chk(n, "mem_we", 32'(bus.mem_we), 32'(e.we));
      chk(n, "mem_addr", 32'(bus.mem_addr), 32'(e.ma));
      if (e.we)
        chk(n, "mem_wdata", bus.mem_wdata, e.mwd);
    end
  endtask

  initial begin
    // reset, then pop from empty stack
    add(I(1,N,0,0,0,0,0,0,0,0,0), E(0,0,0,1023,0,1,0,0,0,0,0,0,0));
    add(I(0,PO,0,0,0,0,0,0,0,0,0), E(1,0,0,1023,0,1,0,0,0,0,0,0,0));
    add(I(0,PO,0,0,0,0,0,0,0,0,0), E(0,1,0,1023,0,1,1,0,0,0,0,0,0));
    add(I(0,N,0,0,0,0,0,0,0,0,0), E(0,0,0,1023,0,1,1,0,0,0,0,0,0));
    add(I(1,N,0,0,0,0,0,0,0,0,0), E(0,0,0,1023,0,1,1,0,0,0,0,0,0));
    add(I(0,N,0,0,0,0,0,0,0,0,0), E(0,0,0,1023,0,1,0,0,0,0,0,0,0));
    // push A, push B, pop
    add(I(0,PU,'hA,0,0,0,0,0,0,0,0), E(0,0,0,1023,0,1,0,0,0,1,1,1023,'hA));
    add(I(0,PU,'hB,0,0,0,0,0,0,0,0), E(0,0,0,1022,0,0,0,0,0,1,1,1022,'hB));
    add(I(0,PO,0,0,0,0,0,0,0,0,0), E(1,0,0,1021,0,0,0,0,0,1,0,1022,0));
    add(I(0,PO,0,0,0,0,0,0,0,0,0), E(0,1,'hB,1022,0,0,0,0,0,0,0,0,0));
    add(I(0,N,0,0,0,0,0,0,0,0,0), E(0,0,'hB,1022,0,0,0,0,0,0,0,0,0));
    // fill to depth 4, overflow, pop
    add(I(0,PU,'hC1,0,0,0,0,0,0,0,0), E(0,0,'hB,1022,0,0,0,0,0,1,1,1022,'hC1));
    add(I(0,PU,'hC2,0,0,0,0,0,0,0,0), E(0,0,'hB,1021,0,0,0,0,0,1,1,1021,'hC2));
    add(I(0,PU,'hC3,0,0,0,0,0,0,0,0), E(0,0,'hB,1020,0,0,0,0,0,1,1,1020,'hC3));
    add(I(0,PU,'hC4,0,0,0,0,0,0,0,0), E(0,0,'hB,1019,1,0,0,0,0,0,0,0,0));
    add(I(0,N,0,0,0,0,0,0,0,0,0), E(0,0,'hB,1019,1,0,1,0,0,0,0,0,0));
    add(I(0,PO,0,0,0,0,0,0,0,0,0), E(1,0,'hB,1019,1,0,1,0,0,1,0,1020,0));
    add(I(0,PO,0,0,0,0,0,0,0,0,0), E(0,1,'hC3,1020,0,0,1,0,0,0,0,0,0));
    // sw, DMA write, lw racing a DMA read
    add(I(0,N,0,0,1,'h10,'h55,0,0,0,0), E(0,0,'hC3,1020,0,0,1,0,0,1,1,'h10,'h55));
    add(I(0,N,0,0,0,0,0,1,1,'h20,'hD0), E(0,0,'hC3,1020,0,0,1,1,0,1,1,'h20,'hD0));
    add(I(0,N,0,1,0,'h10,0,1,0,'h20,0), E(1,0,'hC3,1020,0,0,1,0,0,1,0,'h10,0));
    add(I(0,N,0,1,0,'h10,0,1,0,'h20,0), E(0,1,'h55,1020,0,0,1,0,0,0,0,0,0));
    add(I(0,N,0,0,0,0,0,1,0,'h20,0), E(0,0,'h55,1020,0,0,1,1,0,1,0,'h20,0));
    add(I(0,N,0,0,1,'h11,'h66,0,0,0,0), E(1,0,'h55,1020,0,0,1,0,1,0,0,0,0));
    add(I(0,N,0,0,1,'h11,'h66,0,0,0,0), E(0,0,'h55,1020,0,0,1,0,0,1,1,'h11,'h66));
    // DMA starved by back-to-back stores
    add(I(0,N,0,0,1,'h12,'h71,1,1,'h21,'hE0), E(0,0,'h55,1020,0,0,1,0,0,1,1,'h12,'h71));
    add(I(0,N,0,0,1,'h13,'h72,1,1,'h21,'hE0), E(0,0,'h55,1020,0,0,1,0,0,1,1,'h13,'h72));
    add(I(0,N,0,0,1,'h14,'h73,1,1,'h21,'hE0), E(0,0,'h55,1020,0,0,1,0,0,1,1,'h14,'h73));
    add(I(0,N,0,0,1,'h15,'h74,1,1,'h21,'hE0), E(1,0,'h55,1020,0,0,1,1,0,1,1,'h21,'hE0));
    add(I(0,N,0,0,1,'h15,'h74,0,0,0,0), E(0,0,'h55,1020,0,0,1,0,0,1,1,'h15,'h74));
    // reset during CORE_RD
    add(I(0,N,0,1,0,'h12,0,0,0,0,0), E(1,0,'h55,1020,0,0,1,0,0,1,0,'h12,0));
    add(I(1,N,0,1,0,'h12,0,0,0,0,0), E(0,0,0,1020,0,0,1,0,0,0,0,0,0));
    add(I(0,N,0,0,0,0,0,0,0,0,0), E(0,0,0,1023,0,1,0,0,0,0,0,0,0));

    drive(I(1,N,0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    foreach (vt[n]) begin
      drive(vt[n].i);
      #3;
      applied++;
      check(n, vt[n].e);
      @(posedge clk);
      #1;
    end

    // data returned by the DMA read of 0x20 must be the earlier DMA write
    drive(I(0,N,0,0,0,0,0,1,1,'h22,'h99));
    @(posedge clk); #1;
    drive(I(0,N,0,0,0,0,0,1,0,'h20,0));
    @(posedge clk); #1;
    drive(I(0,N,0,0,0,0,0,0,0,0,0));
    #3;
    applied++;
    chk(100, "dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
    chk(100, "dma_rdata", bus.mem_rdata, 32'hD0);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end
endmodule
